// File: rtl/dct_inv.sv
// 4x4 inverse integer transform: row butterflies fill a transpose buffer,
// then column butterflies with rounding and saturation drain it one column per cycle.
module dct_inv #(
    parameter int SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [3:0][9:0] in_coef,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [3:0][9:0] out_res,
    output logic                  busy
);
    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
    typedef logic [3:0][15:0] quad_t;

    localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [16:0] RND = 17'(RND_I);

    // Both passes share one 16-bit butterfly; the row pass only needs 13 bits of it.
    function automatic quad_t bfly(input quad_t y);
        logic signed [15:0] e0, e1, o0, o1;
        quad_t x;
        e0 = $signed(y[0]) + $signed(y[2]);
        e1 = $signed(y[0]) - $signed(y[2]);
        o0 = ($signed(y[1]) <<< 1) + $signed(y[3]);
        o1 = $signed(y[1]) - ($signed(y[3]) <<< 1);
        x[0] = e0 + o0;
        x[1] = e1 + o1;
        x[2] = e1 - o1;
        x[3] = e0 - o0;
        return x;
    endfunction

    function automatic logic [9:0] rnd_sat(input logic [15:0] v);
        logic signed [16:0] s;
        s = ($signed({v[15], v}) + RND) >>> SHIFT;
        if (s > 17'sd511)  return 10'h1ff;
        if (s < -17'sd512) return 10'h200;
        return s[9:0];
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [12:0] buf_q [4][4];
    logic [12:0] buf_d [4][4];
    quad_t       row_y, row_x, col_y, col_x;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        buf_d   = buf_q;
        for (int k = 0; k < 4; k++) begin
            row_y[k] = {{6{in_coef[k][9]}}, in_coef[k]};
            col_y[k] = {{3{buf_q[k][col_q][12]}}, buf_q[k][col_q]};
        end
        row_x = bfly(row_y);
        col_x = bfly(col_y);
        case (state_q)
            FILL: if (in_valid) begin
                for (int k = 0; k < 4; k++) buf_d[row_q][k] = row_x[k][12:0];
                row_d = row_q + 2'd1;
                if (row_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: if (out_ready) begin
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Buffer is always fully rewritten before it is read, so it needs no reset.
    always_ff @(posedge clk) buf_q <= buf_d;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);

    always_comb begin
        out_res = '0;
        for (int k = 0; k < 4; k++)
            if (out_valid) out_res[k] = rnd_sat(col_x[k]);
    end
endmodule

// File: tb/tb_dct_inv.sv
// Randomized bench for dct_inv with a matrix-form reference model and a scoreboard
// of expected columns checked every cycle.
module tb_dct_inv;
    localparam int SHIFT = 2;
    typedef int blk_t [4][4];
    typedef logic [39:0] col_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [3:0][9:0] in_coef = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [3:0][9:0] out_res;
    logic busy;

    int errors = 0;
    int checks = 0;
    int ordy_mode = 0;
    int stall_cnt = 0;
    int nrows = 0;
    blk_t acc;
    col_t expq[$];

    dct_inv #(.SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [39:0] act, logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic col_t pack4(int a0, int a1, int a2, int a3);
        col_t c;
        c[9:0] = 10'(a0); c[19:10] = 10'(a1); c[29:20] = 10'(a2); c[39:30] = 10'(a3);
        return c;
    endfunction

    // Inverse transform written as two matrix products: T = Y*M^T, X = M*T.
    function automatic void model(input blk_t y, output col_t cols[4]);
        int m[4][4] = '{'{1, 2, 1, 1}, '{1, 1, -1, -2}, '{1, -1, -1, 2}, '{1, -2, 1, -1}};
        int t[4][4];
        int v;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++) begin
                t[r][i] = 0;
                for (int j = 0; j < 4; j++) t[r][i] += m[i][j] * y[r][j];
            end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                v = 0;
                for (int j = 0; j < 4; j++) v += m[i][j] * t[j][c];
                if (SHIFT > 0) v = (v + (1 << (SHIFT - 1))) >>> SHIFT;
                if (v > 511) v = 511;
                if (v < -512) v = -512;
                cols[c][i*10 +: 10] = 10'(v);
            end
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        col_t cols[4];
        if (!rst_n) begin
            nrows = 0;
            expq.delete();
        end else begin
            chk("out_valid", 40'(out_valid), 40'(expq.size() != 0));
            chk("in_ready", 40'(in_ready), 40'(expq.size() == 0));
            chk("busy", 40'(busy), 40'(expq.size() != 0));
            if (out_valid && expq.size() != 0) begin
                chk("column", out_res, expq[0]);
                if (out_ready) void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 4; k++) acc[nrows][k] = int'($signed(in_coef[k]));
                nrows++;
                if (nrows == 4) begin
                    model(acc, cols);
                    for (int c = 0; c < 4; c++) expq.push_back(cols[c]);
                    nrows = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ordy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(3) != 0);
            default: begin
                out_ready = !(expq.size() == 3 && stall_cnt < 3);
                if (!out_ready) stall_cnt++;
            end
        endcase
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 40'(in_ready), 40'd1);
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_out_res", out_res, 40'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_acc();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) chk("row_accept_timeout", 40'd0, 40'd1);
        @(posedge clk); #1;
    endtask

    // gaps: 0 none (in_valid left high), 1 alternate, 2 random
    task automatic send_rows(input blk_t y, input int n, input int gaps);
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < 4; k++) in_coef[k] = 10'(y[r][k]);
            in_valid = 1'b1;
            wait_acc();
            if (gaps == 1 || (gaps == 2 && $urandom_range(1) == 1)) begin
                in_valid = 1'b0;
                in_coef = $urandom();
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((expq.size() != 0 || out_valid) && t < 300) begin @(negedge clk); t++; end
        if (expq.size() != 0 || out_valid) chk("drain_timeout", 40'd0, 40'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        @(negedge clk);
        while (!(out_valid && expq.size() == n) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("wait_q_timeout", 40'd0, 40'd1);
    endtask

    initial begin
        blk_t dc, sat, rb;
        col_t cols[4];
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin dc[r][k] = 0; sat[r][k] = 511; end
        dc[0][0] = 64;

        // Pin the reference model with hand-computed results.
        model(dc, cols);
        for (int c = 0; c < 4; c++) chk("model_dc", cols[c], pack4(16, 16, 16, 16));
        model(sat, cols);
        chk("model_sat_c0", cols[0], pack4(511, -512, 511, -512));
        chk("model_sat_c1", cols[1], pack4(-512, 128, -128, 128));

        do_reset();

        // DC block, first column checked against a literal too
        send_rows(dc, 4, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("dc_first_valid", 40'(out_valid), 40'd1);
        chk("dc_first_col", out_res, pack4(16, 16, 16, 16));
        wait_idle();

        // saturation
        send_rows(sat, 4, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat_col0", out_res, pack4(511, -512, 511, -512));
        @(negedge clk);
        chk("sat_col1", out_res, pack4(-512, 128, -128, 128));
        wait_idle();

        // backpressure on column 1
        ordy_mode = 2; stall_cnt = 0;
        send_rows(dc, 4, 0);
        in_valid = 1'b0;
        wait_idle();
        chk("stall_cycles", 40'(stall_cnt), 40'd3);
        ordy_mode = 0;

        // alternating input gaps
        send_rows(dc, 4, 1);
        wait_idle();

        // reset after two rows, then a fresh block
        send_rows(sat, 2, 0);
        in_valid = 1'b0;
        do_reset();
        send_rows(dc, 4, 0);
        in_valid = 1'b0;
        wait_idle();

        // reset during column 2 of the drain
        send_rows(sat, 4, 0);
        in_valid = 1'b0;
        wait_q(3);
        do_reset();
        send_rows(dc, 4, 0);
        in_valid = 1'b0;
        wait_idle();

        // back-to-back with in_valid held high
        send_rows(dc, 4, 0);
        send_rows(sat, 4, 0);
        in_valid = 1'b0;
        wait_idle();

        // random blocks with random gaps and backpressure
        ordy_mode = 1;
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    rb[r][k] = (b < 4) ? int'($urandom_range(1023)) - 512
                                       : int'($urandom_range(40)) - 20;
            send_rows(rb, 4, 2);
            in_valid = 1'b0;
        end
        wait_idle();
        ordy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
